// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - registered request sequencer driving an external 8-bit ALU (optional MUL via ALU_SEQ_MUL_EN)
module alu_sequencer #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [n-1:0] req_data,
    output logic [2:0]   alu_cntrl,
    output logic [n-1:0] alu_in1,
    output logic [n-1:0] alu_in2,
    input  logic [n-1:0] alu_out,
    input  logic         alu_V,
    input  logic         alu_Z,
    input  logic         alu_cout,
    output logic [n-1:0] acc,
    output logic         flag_V,
    output logic         flag_Z,
    output logic         flag_C,
    output logic         done
);

    localparam logic [3:0] OP_LOAD = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
`ifdef ALU_SEQ_MUL_EN
        ,
        S_MUL
`endif
    } state_t;

    state_t       r_state;
    logic [3:0]   r_op;
    logic [n-1:0] r_dat;
    logic [n-1:0] r_acc;
    logic         r_flag_v;
    logic         r_flag_z;
    logic         r_flag_c;
    logic         r_done;
    logic         r_req_ready;

    logic [2:0]   w_alu_cntrl;
    logic [n-1:0] w_alu_in1;
    logic [n-1:0] w_alu_in2;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

    logic [n-1:0]  r_p;
    logic [n-1:0]  r_d;
    logic [n-1:0]  r_m;
    logic [CW-1:0] r_cnt;
    logic          r_lost;
    logic          r_ovf;
    logic [n-1:0]  w_p_next;
    logic          w_ovf_next;

    // Partial product and overflow after this cycle's conditional add; a
    // multiplicand bit shifted out earlier counts as overflow once it is used.
    always_comb begin
        w_p_next   = r_m[0] ? alu_out : r_p;
        w_ovf_next = r_ovf | (r_m[0] & (alu_cout | r_lost));
    end
`endif

    // ALU operand muxing: idle default is cntrl=111, in1=acc, in2=0.
    always_comb begin
        w_alu_cntrl = 3'b111;
        w_alu_in1   = r_acc;
        w_alu_in2   = '0;
        if (r_state == S_EXEC && !r_op[3]) begin
            w_alu_cntrl = r_op[2:0];
            w_alu_in2   = r_dat;
        end
`ifdef ALU_SEQ_MUL_EN
        if (r_state == S_MUL) begin
            w_alu_cntrl = 3'b000;
            w_alu_in1   = r_p;
            w_alu_in2   = r_d;
        end
`endif
    end

    // Sequencer FSM with registered accumulator, flags, handshake and done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_dat       <= '0;
            r_acc       <= '0;
            r_flag_v    <= 1'b0;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_done      <= 1'b0;
            r_req_ready <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
            r_p         <= '0;
            r_d         <= '0;
            r_m         <= '0;
            r_cnt       <= '0;
            r_lost      <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_op        <= req_op;
                        r_dat       <= req_data;
                        r_req_ready <= 1'b0;
                        r_state     <= S_EXEC;
`ifdef ALU_SEQ_MUL_EN
                        if (req_op == 4'b1001) begin
                            r_state <= S_MUL;
                            r_p     <= '0;
                            r_d     <= r_acc;
                            r_m     <= req_data;
                            r_cnt   <= '0;
                            r_lost  <= 1'b0;
                            r_ovf   <= 1'b0;
                        end
`endif
                    end
                end
                S_EXEC: begin
                    if (!r_op[3]) begin
                        r_acc    <= alu_out;
                        r_flag_v <= alu_V;
                        r_flag_z <= alu_Z;
                        r_flag_c <= alu_cout;
                    end else if (r_op == OP_LOAD) begin
                        r_acc    <= r_dat;
                        r_flag_v <= 1'b0;
                        r_flag_z <= (r_dat == '0);
                        r_flag_c <= 1'b0;
                    end
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
`ifdef ALU_SEQ_MUL_EN
                S_MUL: begin
                    r_p    <= w_p_next;
                    r_ovf  <= w_ovf_next;
                    r_lost <= r_lost | r_d[n-1];
                    r_d    <= r_d << 1;
                    r_m    <= r_m >> 1;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_acc    <= w_p_next;
                        r_flag_c <= w_ovf_next;
                        r_flag_v <= 1'b0;
                        r_flag_z <= (w_p_next == '0);
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign alu_cntrl = w_alu_cntrl;
    assign alu_in1   = w_alu_in1;
    assign alu_in2   = w_alu_in2;
    assign acc       = r_acc;
    assign flag_V    = r_flag_v;
    assign flag_Z    = r_flag_z;
    assign flag_C    = r_flag_c;
    assign done      = r_done;

endmodule
